seq_detector_param: RTL and testbench



---
 rtl/seq_detector_param.sv | 129 ++++++++++++
 tb/tb_seq_detector_param.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// Runtime-configurable serial pattern detector with a saturating match counter.
// Latency: out registers on the same edge that samples the completing bit; no backpressure. Optional macro: SEQDET_CNT_CLR_EN (adds cnt_clr).
module seq_detector_param #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pat,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               in_valid,
  input  logic               ina,
`ifdef SEQDET_CNT_CLR_EN
  input  logic               cnt_clr,
`endif
  output logic               out,
  output logic [CNT_W-1:0]   match_cnt,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    FILL = 2'b01,
    HUNT = 2'b10
  } state_e;

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               out_q, out_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [MAX_LEN-1:0] hist_n;
  logic [LEN_W-1:0]   fill_n;
  logic [MAX_LEN-1:0] mask;
  logic               hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
      hist_q  <= '0;
      fill_q  <= '0;
      out_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
    end
  end

  // Only the low len bits of history take part in the compare.
  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len_q));
    end
  end

  assign hist_n = {hist_q[MAX_LEN-2:0], ina};
  assign fill_n = (fill_q < len_q) ? fill_q + 1'b1 : fill_q;
  assign hit    = (((hist_n ^ pat_q) & mask) == '0);

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    out_d   = 1'b0;
    cnt_d   = cnt_q;

    if (cfg_we) begin
      pat_d   = cfg_pat;
      len_d   = (cfg_len > MAX_LEN_L) ? MAX_LEN_L : cfg_len;
      ovl_d   = cfg_overlap;
      hist_d  = '0;
      fill_d  = '0;
      state_d = (cfg_len != '0) ? FILL : IDLE;
    end else if (in_valid && (state_q != IDLE)) begin
      hist_d = hist_n;
      fill_d = fill_n;
      if (fill_n == len_q) begin
        state_d = HUNT;
        if (hit) begin
          out_d = 1'b1;
          if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
          // Non-overlapping mode: the next match must be built from fresh bits.
          if (!ovl_q) begin
            fill_d  = '0;
            state_d = FILL;
          end
        end
      end else begin
        state_d = FILL;
      end
    end

`ifdef SEQDET_CNT_CLR_EN
    if (cnt_clr) begin
      cnt_d = '0;
    end
`endif
  end

  assign out       = out_q;
  assign match_cnt = cnt_q;
  assign state     = state_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param: expected pulses queued per driven cycle, popped after the edge.
module tb_seq_detector_param;

  logic       clk;
  logic       rst;
  logic       cfg_we;
  logic [7:0] cfg_pat;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic       in_valid;
  logic       ina;
  logic       out_o;
  logic [7:0] cnt_o;
  logic [1:0] state_o;
  logic       out_s;
  logic [1:0] cnt_s;
  logic [1:0] state_s;
`ifdef SEQDET_CNT_CLR_EN
  logic       cnt_clr;
`endif

  int   checks   = 0;
  int   failures = 0;
  logic exp_q[$];
  logic e;

  seq_detector_param dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .in_valid(in_valid), .ina(ina),
`ifdef SEQDET_CNT_CLR_EN
    .cnt_clr(cnt_clr),
`endif
    .out(out_o), .match_cnt(cnt_o), .state(state_o)
  );

  seq_detector_param #(.CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .in_valid(in_valid), .ina(ina),
`ifdef SEQDET_CNT_CLR_EN
    .cnt_clr(cnt_clr),
`endif
    .out(out_s), .match_cnt(cnt_s), .state(state_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic b);
    in_valid = v;
    ina      = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic o,
                     input logic v, input logic b);
    cfg_we = 1'b1; cfg_pat = p; cfg_len = l; cfg_overlap = o;
    in_valid = v; ina = b;
    @(posedge clk);
    #1;
    cfg_we = 1'b0; in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0; cfg_we = 1'b0; in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    checks++;
    if (out_o !== 1'b0 || cnt_o !== 8'd0 || state_o !== 2'b00) begin
      failures++;
      $display("FAIL reset: out=%0b cnt=%0d state=%b, expected 0 0 00", out_o, cnt_o, state_o);
    end
    @(posedge clk); #1; rst = 1'b1;
    // IDLE ignores valid input entirely.
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(1'b0);
      drive(1'b1, 1'b1);
      e = exp_q.pop_front();
      checks++;
      if (out_o !== e || state_o !== 2'b00) begin
        failures++;
        $display("FAIL idle[%0d]: out=%0b state=%b, expected %0b 00", i, out_o, state_o, e);
      end
    end
  endtask

  task automatic test_overlap();
    logic bits[6] = '{1, 1, 1, 1, 0, 1};
    logic expo[6] = '{0, 0, 1, 1, 0, 0};
    do_reset();
    cfg(8'b111, 4'd3, 1'b1, 1'b0, 1'b0);
    checks++;
    if (state_o !== 2'b01 || out_o !== 1'b0) begin
      failures++;
      $display("FAIL cfg_fill: state=%b out=%0b, expected 01 0", state_o, out_o);
    end
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(expo[i]);
      drive(1'b1, bits[i]);
      e = exp_q.pop_front();
      checks++;
      if (out_o !== e) begin
        failures++;
        $display("FAIL ovl_out[%0d]: out=%0b expected %0b", i, out_o, e);
      end
    end
    checks++;
    if (cnt_o !== 8'd2 || state_o !== 2'b10) begin
      failures++;
      $display("FAIL ovl_cnt: cnt=%0d state=%b, expected 2 10", cnt_o, state_o);
    end
  endtask

  task automatic test_no_overlap();
    logic       expo[6] = '{0, 0, 1, 0, 0, 1};
    logic [1:0] exps[6] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
    do_reset();
    cfg(8'b111, 4'd3, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(expo[i]);
      drive(1'b1, 1'b1);
      e = exp_q.pop_front();
      checks++;
      if (out_o !== e || state_o !== exps[i]) begin
        failures++;
        $display("FAIL novl[%0d]: out=%0b state=%b, expected %0b %b", i, out_o, state_o, e, exps[i]);
      end
    end
    checks++;
    if (cnt_o !== 8'd2) begin
      failures++;
      $display("FAIL novl_cnt: cnt=%0d expected 2", cnt_o);
    end
  endtask

  task automatic test_gaps();
    logic bits[7] = '{1, 0, 1, 1, 0, 1, 1};
    logic expo[7] = '{0, 0, 0, 1, 0, 0, 1};
    do_reset();
    cfg(8'b1011, 4'd4, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(expo[i]);
      drive(1'b1, bits[i]);
      e = exp_q.pop_front();
      checks++;
      if (out_o !== e) begin
        failures++;
        $display("FAIL gap_bit[%0d]: out=%0b expected %0b", i, out_o, e);
      end
      if (i < 6) begin
        for (int g = 0; g < 2; g++) begin
          exp_q.push_back(1'b0);
          drive(1'b0, ~bits[i]);
          e = exp_q.pop_front();
          checks++;
          if (out_o !== e) begin
            failures++;
            $display("FAIL gap_idle[%0d.%0d]: out=%0b expected %0b", i, g, out_o, e);
          end
        end
      end
    end
    checks++;
    if (cnt_o !== 8'd2 || state_o !== 2'b10) begin
      failures++;
      $display("FAIL gap_cnt: cnt=%0d state=%b, expected 2 10", cnt_o, state_o);
    end
  endtask

  task automatic test_saturate();
    logic [1:0] expc[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset();
    cfg(8'b1, 4'd1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(1'b1);
      drive(1'b1, 1'b1);
      e = exp_q.pop_front();
      checks++;
      if (out_s !== e || cnt_s !== expc[i]) begin
        failures++;
        $display("FAIL sat[%0d]: out=%0b cnt=%0d, expected %0b %0d", i, out_s, cnt_s, e, expc[i]);
      end
    end
    checks++;
    if (cnt_o !== 8'd5) begin
      failures++;
      $display("FAIL sat_wide: cnt=%0d expected 5", cnt_o);
    end
  endtask

  task automatic test_clamp();
    logic [7:0] p;
    do_reset();
    p = 8'hA5;
    cfg(p, 4'd15, 1'b1, 1'b0, 1'b0);
    for (int i = 7; i >= 0; i--) begin
      exp_q.push_back(i == 0);
      drive(1'b1, p[i]);
      e = exp_q.pop_front();
      checks++;
      if (out_o !== e) begin
        failures++;
        $display("FAIL clamp[%0d]: out=%0b expected %0b", i, out_o, e);
      end
    end
    cfg(8'hFF, 4'd0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1);
    checks++;
    if (state_o !== 2'b00 || out_o !== 1'b0) begin
      failures++;
      $display("FAIL len0: state=%b out=%0b, expected 00 0", state_o, out_o);
    end
  endtask

  task automatic test_midstream();
    logic expo[4] = '{0, 0, 0, 1};
    logic vld[4]  = '{1, 1, 1, 1};
    do_reset();
    cfg(8'b111, 4'd3, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    cfg(8'b111, 4'd3, 1'b1, 1'b1, 1'b1);
    checks++;
    if (out_o !== 1'b0 || state_o !== 2'b01) begin
      failures++;
      $display("FAIL mid_cfg: out=%0b state=%b, expected 0 01", out_o, state_o);
    end
    for (int i = 1; i < 4; i++) begin
      exp_q.push_back(expo[i]);
      drive(vld[i], 1'b1);
      e = exp_q.pop_front();
      checks++;
      if (out_o !== e) begin
        failures++;
        $display("FAIL mid_bit[%0d]: out=%0b expected %0b", i, out_o, e);
      end
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (out_o !== 1'b0 || cnt_o !== 8'd0 || state_o !== 2'b00) begin
      failures++;
      $display("FAIL async_rst: out=%0b cnt=%0d state=%b, expected 0 0 00", out_o, cnt_o, state_o);
    end
    @(posedge clk); #1; rst = 1'b1;
  endtask

`ifdef SEQDET_CNT_CLR_EN
  task automatic test_cnt_clr();
    do_reset();
    cfg(8'b111, 4'd3, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    exp_q.push_back(1'b1);
    cnt_clr = 1'b1;
    drive(1'b1, 1'b1);
    cnt_clr = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (out_o !== e || cnt_o !== 8'd0) begin
      failures++;
      $display("FAIL clr_hit: out=%0b cnt=%0d, expected %0b 0", out_o, cnt_o, e);
    end
    exp_q.push_back(1'b1);
    drive(1'b1, 1'b1);
    e = exp_q.pop_front();
    checks++;
    if (out_o !== e || cnt_o !== 8'd1) begin
      failures++;
      $display("FAIL clr_next: out=%0b cnt=%0d, expected %0b 1", out_o, cnt_o, e);
    end
  endtask
`endif

  initial begin
    rst = 1'b0; cfg_we = 1'b0; cfg_pat = '0; cfg_len = '0; cfg_overlap = 1'b0;
    in_valid = 1'b0; ina = 1'b0;
`ifdef SEQDET_CNT_CLR_EN
    cnt_clr = 1'b0;
`endif
    test_reset();
    test_overlap();
    test_no_overlap();
    test_gaps();
    test_saturate();
    test_clamp();
    test_midstream();
`ifdef SEQDET_CNT_CLR_EN
    test_cnt_clr();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
